// File: rtl/alv_vhdl_mac_accum_pkg.sv
// Shared types and constants for the MAC accumulator slice.
package alv_vhdl_mac_accum_pkg;

  localparam int unsigned DIN_WIDTH_DEF = 32;
  localparam int unsigned LEN_WIDTH_DEF = 16;
  localparam int unsigned ACC_WIDTH_DEF = 48;

  // Clip limits for the default product width.
  localparam logic [DIN_WIDTH_DEF-1:0] SAT_POS_DEF = 32'h7FFF_FFFF;
  localparam logic [DIN_WIDTH_DEF-1:0] SAT_NEG_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alv_vhdl_sat_trunc.sv
// Combinational signed saturator: narrows an ACC_WIDTH sum to DIN_WIDTH
// and flags when clipping occurred.
module alv_vhdl_sat_trunc
  import alv_vhdl_mac_accum_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned DIN_WIDTH = DIN_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [DIN_WIDTH-1:0] dout_o,
  output logic                 sat_o
);

  localparam int unsigned HI_WIDTH = ACC_WIDTH - DIN_WIDTH + 1;

  // The sum fits when every bit from the output sign bit upward is a copy of it.
  logic [HI_WIDTH-1:0] hi;
  assign hi = acc_i[ACC_WIDTH-1:DIN_WIDTH-1];

  // Select either the truncated value or the limit matching the true sign.
  always_comb begin
    dout_o = acc_i[DIN_WIDTH-1:0];
    sat_o  = 1'b0;
    if (!((hi == '0) || (hi == '1))) begin
      sat_o  = 1'b1;
      dout_o = acc_i[ACC_WIDTH-1] ? {1'b1, {(DIN_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DIN_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/alv_vhdl_mac_accum.sv
// Dot-product accumulator behind a multiplier: sums len signed products,
// then presents a saturated result with a valid/ready handshake.
module alv_vhdl_mac_accum
  import alv_vhdl_mac_accum_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 in_valid,
  input  logic [DIN_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIN_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int unsigned EXT_WIDTH = ACC_WIDTH - DIN_WIDTH;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [DIN_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0] acc_sum;
  logic [DIN_WIDTH-1:0] sat_data;
  logic                 sat_flag;
  logic                 last_term;

  assign acc_sum   = acc_q + {{EXT_WIDTH{in_data[DIN_WIDTH-1]}}, in_data};
  assign last_term = (cnt_q == len_q - LEN_WIDTH'(1));

  // The final result is saturated from acc+in_data so it is ready the cycle after the last transfer.
  alv_vhdl_sat_trunc #(
    .ACC_WIDTH(ACC_WIDTH),
    .DIN_WIDTH(DIN_WIDTH)
  ) u_sat (
    .acc_i (acc_sum),
    .dout_o(sat_data),
    .sat_o (sat_flag)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Next-state and datapath updates; everything holds while ce is low.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_d = ST_ACCUM;
              acc_d   = '0;
              cnt_d   = '0;
              len_d   = len;
            end else begin
              state_d    = ST_DONE;
              out_data_d = '0;
              out_sat_d  = 1'b0;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + LEN_WIDTH'(1);
            if (last_term) begin
              state_d    = ST_DONE;
              out_data_d = sat_data;
              out_sat_d  = sat_flag;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Single state register; reset wins over ce and aborts any partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_alv_vhdl_mac_accum.sv
// Scoreboard bench for the MAC accumulator: stimulus queues expected results,
// a monitor pops and compares on each accepted output.
module tb_alv_vhdl_mac_accum;
  import alv_vhdl_mac_accum_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset, ce, start, in_valid, out_ready;
  logic [LW-1:0] len;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_sat, busy;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  alv_vhdl_mac_accum #(
    .DIN_WIDTH(32),
    .LEN_WIDTH(16),
    .ACC_WIDTH(48)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  bit            stalled = 0;
  logic [DW-1:0] held_d;
  logic          held_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [LW-1:0] l, input logic [DW-1:0] d,
                           input logic s, input bit expect_result);
    exp_t x;
    if (expect_result) begin
      x.d = d;
      x.s = s;
      sb.push_back(x);
    end
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      done = in_ready && ce && !reset;
      tick();
    end
    check("push_accepted", 64'(done), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (!busy) ok = 1;
      else tick();
    end
    check("reach_idle", 64'(ok), 64'd1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          stalled = 0;
        end else if (out_valid) begin
          if (stalled) begin
            check("hold_data", 64'(out_data), 64'(held_d));
            check("hold_sat", 64'(out_sat), 64'(held_s));
          end
          if (ce && out_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_result", 64'(out_valid), 64'd0);
            end else begin
              e = sb.pop_front();
              check("result_data", 64'(out_data), 64'(e.d));
              check("result_sat", 64'(out_sat), 64'(e.s));
            end
            stalled = 0;
          end else if (!stalled) begin
            stalled = 1;
            held_d  = out_data;
            held_s  = out_sat;
          end
        end else begin
          stalled = 0;
        end
      end
    join_none

    // Reset with products presented: they must be discarded.
    reset = 1'b1; ce = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b1; in_data = 32'd55; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);

    // len=4: 10-3+7+100 = 114, one-cycle latency after the last transfer.
    start_vec(16'd4, 32'd114, 1'b0, 1'b1);
    check("a_in_ready", 64'(in_ready), 64'd1);
    push(32'd10);
    push(32'hFFFF_FFFD);
    push(32'd7);
    push(32'd100);
    check("a_latency_valid", 64'(out_valid), 64'd1);
    check("a_done_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("a_back_idle", 64'(busy), 64'd0);

    // Saturation both directions.
    start_vec(16'd3, SAT_POS_DEF, 1'b1, 1'b1);
    repeat (3) push(SAT_POS_DEF);
    wait_idle();
    start_vec(16'd3, SAT_NEG_DEF, 1'b1, 1'b1);
    repeat (3) push(SAT_NEG_DEF);
    wait_idle();

    // Exact limits are not clipped; one beyond them is.
    start_vec(16'd2, 32'h7FFF_FFFF, 1'b0, 1'b1);
    push(32'h7FFF_FFFE); push(32'd1);
    wait_idle();
    start_vec(16'd2, 32'h8000_0000, 1'b0, 1'b1);
    push(32'h8000_0000); push(32'd0);
    wait_idle();
    start_vec(16'd2, 32'h7FFF_FFFF, 1'b1, 1'b1);
    push(32'h7FFF_FFFF); push(32'd1);
    wait_idle();
    start_vec(16'd2, 32'h8000_0000, 1'b1, 1'b1);
    push(32'h8000_0000); push(32'hFFFF_FFFF);
    wait_idle();
    start_vec(16'd2, 32'hFFFF_FFF5, 1'b0, 1'b1);
    push(32'hFFFF_FFFB); push(32'hFFFF_FFFA);
    wait_idle();

    // len=0 goes straight to DONE with a zero result.
    start_vec(16'd0, 32'd0, 1'b0, 1'b1);
    check("c_len0_valid", 64'(out_valid), 64'd1);
    check("c_len0_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("c_len0_in_ready2", 64'(in_ready), 64'd0);
    check("c_len0_idle", 64'(busy), 64'd0);

    // Bubbles, ce low mid-vector, stalled output, start ignored in DONE.
    out_ready = 1'b0;
    start_vec(16'd5, 32'd1286, 1'b0, 1'b1);
    push(32'hFFFF_FFEC);
    tick();
    push(32'd300);
    tick();
    ce = 1'b0; in_valid = 1'b1; in_data = 32'd7;
    repeat (3) tick();
    check("d_ce_low_in_ready", 64'(in_ready), 64'd1);
    ce = 1'b1;
    push(32'd7);
    tick();
    push(32'hFFFF_FFFF);
    tick();
    push(32'd1000);
    check("d_done_valid", 64'(out_valid), 64'd1);
    start = 1'b1; len = 16'd2;
    tick();
    start = 1'b0; len = '0;
    repeat (3) tick();
    check("d_stall_valid", 64'(out_valid), 64'd1);
    check("d_stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; start = 1'b1; len = 16'd3;
    tick();
    start = 1'b0; len = '0;
    check("d_release_idle", 64'(busy), 64'd0);
    check("d_release_valid", 64'(out_valid), 64'd0);

    // Reset mid-vector aborts the sum; next vector starts clean.
    start_vec(16'd6, 32'd0, 1'b0, 1'b0);
    push(32'd1000);
    push(32'd2000);
    in_valid = 1'b1; in_data = 32'd999; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("e_abort_busy", 64'(busy), 64'd0);
    check("e_abort_valid", 64'(out_valid), 64'd0);
    check("e_abort_in_ready", 64'(in_ready), 64'd0);
    start_vec(16'd2, 32'd3, 1'b0, 1'b1);
    push(32'd1);
    push(32'd2);
    wait_idle();

    repeat (2) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
